// File: rtl/bitwise_arbiter_pkg.sv
// Shared constants for the bitwise arbiter: logic-unit opcodes and
// the result-stage FSM state encodings.
package bitwise_arbiter_pkg;

  localparam logic [1:0] OP_OR  = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOT = 2'b11;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/bitwise_arbiter_if.sv
// Bundle of both requester handshakes plus the result handshake.
// master = client side (bench / consumers), slave = the arbiter.
interface bitwise_arbiter_if #(
  parameter int WIDTH = 16
);
  logic             req0_valid;
  logic             req0_ready;
  logic [1:0]       req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;

  logic             req1_valid;
  logic             req1_ready;
  logic [1:0]       req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;

  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_out;
  logic             res_id;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output res_ready,
    input  req0_ready, req1_ready, res_valid, res_out, res_id
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  res_ready,
    output req0_ready, req1_ready, res_valid, res_out, res_id
  );
endinterface

// File: rtl/bitwise_arbiter_unit.sv
// Combinational word-wide logic unit: per-bit OR/AND/XOR/NOT gate slices
// feeding a 4-way word mux selected by the opcode.
module bitwise_unit
  import bitwise_arbiter_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH-1:0] or_w;
  logic [WIDTH-1:0] and_w;
  logic [WIDTH-1:0] xor_w;
  logic [WIDTH-1:0] not_w;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign or_w[gi]  = a[gi] | b[gi];
      assign and_w[gi] = a[gi] & b[gi];
      assign xor_w[gi] = a[gi] ^ b[gi];
      assign not_w[gi] = ~a[gi];
    end
  endgenerate

  always_comb begin
    y = or_w;
    case (op)
      OP_OR:   y = or_w;
      OP_AND:  y = and_w;
      OP_XOR:  y = xor_w;
      OP_NOT:  y = not_w;
      default: y = or_w;
    endcase
  end

endmodule

// File: rtl/bitwise_arbiter.sv
// Round-robin arbiter sharing one bitwise_unit between two requesters,
// with a one-entry registered result stage (EMPTY/FULL).
module bitwise_arbiter
  import bitwise_arbiter_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic              clk,
  input logic              rst_n,
  bitwise_arbiter_if.slave bus
);

  state_t           state_reg, state_next;
  logic             last_grant_reg;
  logic [WIDTH-1:0] res_out_reg;
  logic             res_id_reg;

  logic             any_valid;
  logic             grant;
  logic             can_accept;
  logic             accept;
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] sel_a, sel_b, unit_y;

  // With both valid the requester not granted last wins; otherwise the
  // lone valid one (grant defaults to 0 when idle).
  always_comb begin
    any_valid = bus.req0_valid | bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) grant = ~last_grant_reg;
    else                                  grant = bus.req1_valid;
  end

  always_comb begin
    state_next = state_reg;
    can_accept = 1'b0;
    case (state_reg)
      ST_EMPTY: can_accept = rst_n;
      ST_FULL:  can_accept = rst_n & bus.res_ready;
      default:  can_accept = 1'b0;
    endcase
    accept = can_accept & any_valid;
    if (accept)
      state_next = ST_FULL;
    else if (state_reg == ST_FULL && can_accept)
      state_next = ST_EMPTY;
  end

  assign bus.req0_ready = can_accept & ~grant;
  assign bus.req1_ready = can_accept & grant;

  assign sel_op = grant ? bus.req1_op : bus.req0_op;
  assign sel_a  = grant ? bus.req1_a  : bus.req0_a;
  assign sel_b  = grant ? bus.req1_b  : bus.req0_b;

  bitwise_unit #(.WIDTH(WIDTH)) u_unit (
    .op (sel_op),
    .a  (sel_a),
    .b  (sel_b),
    .y  (unit_y)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= ST_EMPTY;
      last_grant_reg <= 1'b1;
      res_out_reg    <= '0;
      res_id_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        res_out_reg    <= unit_y;
        res_id_reg     <= grant;
        last_grant_reg <= grant;
      end
    end
  end

  assign bus.res_valid = (state_reg == ST_FULL);
  assign bus.res_out   = res_out_reg;
  assign bus.res_id    = res_id_reg;

endmodule

// File: tb/tb_bitwise_arbiter.sv
// Scoreboard bench for bitwise_arbiter: accepted requests push expected
// results, consumed results pop and compare; directed checks cover
// fairness, backpressure, drain and reset.
module tb_bitwise_arbiter;
  import bitwise_arbiter_pkg::*;

  localparam int WIDTH = 16;

  typedef struct {
    logic             id;
    logic [WIDTH-1:0] data;
  } exp_t;

  logic clk;
  logic rst_n;
  bitwise_arbiter_if #(.WIDTH(WIDTH)) bus ();

  bitwise_arbiter #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [WIDTH-1:0] model(input logic [1:0] op,
                                             input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    case (op)
      2'b00:   return a | b;
      2'b01:   return a & b;
      2'b10:   return a ^ b;
      default: return ~a;
    endcase
  endfunction

  // Monitor: sampled on the falling edge, i.e. the handshakes that fire at the next rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (bus.res_valid && bus.res_ready) begin
        if (sb.size() == 0) check("sb_underrun", sb.size(), 1);
        else begin
          e = sb.pop_front();
          check("sb_data", bus.res_out, e.data);
          check("sb_id", bus.res_id, e.id);
          $display("txn id=%0d res=%04h", bus.res_id, bus.res_out);
        end
      end
      if (bus.req0_valid && bus.req0_ready) begin
        e.id = 1'b0;
        e.data = model(bus.req0_op, bus.req0_a, bus.req0_b);
        sb.push_back(e);
      end
      if (bus.req1_valid && bus.req1_ready) begin
        e.id = 1'b1;
        e.data = model(bus.req1_op, bus.req1_a, bus.req1_b);
        sb.push_back(e);
      end
    end
  end

  task automatic send(input logic id, input logic [1:0] op,
                      input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic rdy;
    rdy = 1'b0;
    if (id) begin
      bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      rdy = id ? bus.req1_ready : bus.req0_ready;
      if (rdy) break;
    end
    if (!rdy) check("accept_timeout", rdy, 1);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask

  logic [1:0]       op_tab  [4];
  logic [WIDTH-1:0] exp_tab [4];

  initial begin
    op_tab  = '{OP_OR, OP_AND, OP_XOR, OP_NOT};
    exp_tab = '{16'h3FF3, 16'h0CC0, 16'h3333, 16'hC33C};

    rst_n = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_op = 2'b00; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_valid = 1'b1; bus.req1_op = 2'b00; bus.req1_a = '0; bus.req1_b = '0;
    bus.res_ready = 1'b1;

    // Reset state, readys gated while in reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_res_out", bus.res_out, 0);
    check("rst_res_id", bus.res_id, 0);
    check("rst_ready0", bus.req0_ready, 0);
    check("rst_ready1", bus.req1_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    @(posedge clk); #1;

    // Contention right after reset: grants 0,1,0,1, one result per cycle
    bus.req0_valid = 1'b1; bus.req0_op = OP_AND; bus.req0_a = 16'hF0F0; bus.req0_b = 16'hFF00;
    bus.req1_valid = 1'b1; bus.req1_op = OP_XOR; bus.req1_a = 16'h1234; bus.req1_b = 16'hFFFF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check("cont_res_valid", bus.res_valid, 1);
        check("cont_res_id", bus.res_id, (i - 1) % 2);
      end
      if (i < 4) begin
        check("cont_ready0", bus.req0_ready, (i % 2 == 0) ? 1 : 0);
        check("cont_ready1", bus.req1_ready, (i % 2 == 1) ? 1 : 0);
      end
      if (i == 3) begin
        @(posedge clk); #1;
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      end
    end
    @(posedge clk); #1;

    // Single OR on requester 0
    send(1'b0, OP_OR, 16'hAAAA, 16'h5555);
    @(negedge clk);
    check("or0_valid", bus.res_valid, 1);
    check("or0_out", bus.res_out, 16'hFFFF);
    check("or0_id", bus.res_id, 0);

    // Every opcode on requester 1
    for (int k = 0; k < 4; k++) begin
      send(1'b1, op_tab[k], 16'h3CC3, 16'h0FF0);
      @(negedge clk);
      check("op1_out", bus.res_out, exp_tab[k]);
      check("op1_id", bus.res_id, 1);
    end
    @(posedge clk); #1;

    // Backpressure: held result, both readys 0, then the other requester wins
    bus.res_ready = 1'b0;
    send(1'b0, OP_XOR, 16'h1234, 16'h00FF);
    bus.req0_valid = 1'b1; bus.req0_op = OP_OR;  bus.req0_a = 16'h0001; bus.req0_b = 16'h0002;
    bus.req1_valid = 1'b1; bus.req1_op = OP_AND; bus.req1_a = 16'hABCD; bus.req1_b = 16'h0FF0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_out", bus.res_out, 16'h12CB);
      check("bp_id", bus.res_id, 0);
      check("bp_valid", bus.res_valid, 1);
      check("bp_ready0", bus.req0_ready, 0);
      check("bp_ready1", bus.req1_ready, 0);
    end
    @(posedge clk); #1;
    bus.res_ready = 1'b1;
    @(negedge clk);
    check("bp_rel_ready0", bus.req0_ready, 0);
    check("bp_rel_ready1", bus.req1_ready, 1);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    @(negedge clk);
    check("bp_next_id", bus.res_id, 1);
    check("bp_next_out", bus.res_out, 16'h0BC0);

    // Drain to empty: result register keeps its value
    @(negedge clk);
    check("drain_valid", bus.res_valid, 0);
    check("drain_out", bus.res_out, 16'h0BC0);
    @(posedge clk); #1;

    // Reset while FULL with res_ready=0
    bus.res_ready = 1'b0;
    send(1'b0, OP_NOT, 16'h0F0F, 16'h0000);
    bus.req0_valid = 1'b1; bus.req0_op = OP_OR;  bus.req0_a = 16'h00F0; bus.req0_b = 16'h0F00;
    bus.req1_valid = 1'b1; bus.req1_op = OP_XOR; bus.req1_a = 16'h5A5A; bus.req1_b = 16'hFFFF;
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_ready0", bus.req0_ready, 0);
    check("mid_rst_ready1", bus.req1_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.delete();
    @(negedge clk);
    check("mid_rst_valid", bus.res_valid, 0);
    check("mid_rst_out", bus.res_out, 0);
    check("post_rst_ready0", bus.req0_ready, 1);
    check("post_rst_ready1", bus.req1_ready, 0);
    @(posedge clk); #1;
    bus.res_ready = 1'b1;
    bus.req0_valid = 1'b0;
    @(negedge clk);
    check("post_rst_id", bus.res_id, 0);
    check("post_rst_res", bus.res_out, 16'h0FF0);
    @(posedge clk); #1;
    bus.req1_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
